// File: rtl/lif_neuron_scheduler.sv
// LIF neuron scheduler: shares one combinational neuron datapath
// across NUM_NEURONS virtual neurons, one neuron per cycle.
module lif_neuron_scheduler #(
  parameter int N_STAGES       = 3,
  parameter int NUM_NEURONS    = 4,
  parameter int MEMBRANE_BITS  = N_STAGES + 2,
  parameter int THRESHOLD_BITS = MEMBRANE_BITS - 1,
  parameter int IDX_W          = $clog2(NUM_NEURONS),
  localparam int INPUTS        = 2**N_STAGES
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_we,
  input  logic [IDX_W:0]            cfg_addr,
  input  logic [INPUTS-1:0]         cfg_wdata,
  input  logic                      clear,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [INPUTS-1:0]         in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_NEURONS-1:0]    out_spikes,
  output logic                      busy,
  output logic [INPUTS-1:0]         dp_inputs,
  output logic [INPUTS-1:0]         dp_weights,
  output logic [MEMBRANE_BITS-1:0]  dp_last_membrane,
  output logic                      dp_was_spike,
  output logic [THRESHOLD_BITS-1:0] dp_threshold,
  output logic [2:0]                dp_shift,
  input  logic [MEMBRANE_BITS-1:0]  dp_new_membrane,
  input  logic                      dp_is_spike
);

  localparam logic [IDX_W:0] A_THR = (IDX_W+1)'(NUM_NEURONS);
  localparam logic [IDX_W:0] A_SHF = (IDX_W+1)'(NUM_NEURONS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [IDX_W-1:0]          r_idx;
  logic [INPUTS-1:0]         r_weights  [NUM_NEURONS];
  logic [MEMBRANE_BITS-1:0]  r_membrane [NUM_NEURONS];
  logic [NUM_NEURONS-1:0]    r_was_spike;
  logic [NUM_NEURONS-1:0]    r_acc;
  logic [NUM_NEURONS-1:0]    r_out_spikes;
  logic [INPUTS-1:0]         r_inputs;
  logic [THRESHOLD_BITS-1:0] r_threshold;
  logic [2:0]                r_shift;

  logic                   w_last;
  logic [NUM_NEURONS-1:0] w_acc_next;

  assign w_last     = (r_idx == IDX_W'(NUM_NEURONS - 1));
  assign w_acc_next = r_acc | (NUM_NEURONS'(dp_is_spike) << r_idx);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Clear precedes the input latch so a coincident timestep starts at zero
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx        <= '0;
      r_was_spike  <= '0;
      r_acc        <= '0;
      r_out_spikes <= '0;
      r_inputs     <= '0;
      r_threshold  <= THRESHOLD_BITS'(5);
      r_shift      <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        r_weights[i]  <= '1;
        r_membrane[i] <= '0;
      end
    end else if (r_state == S_IDLE) begin
      if (clear) begin
        r_was_spike <= '0;
        for (int i = 0; i < NUM_NEURONS; i++) r_membrane[i] <= '0;
      end
      if (cfg_we) begin
        if (!cfg_addr[IDX_W])
          r_weights[cfg_addr[IDX_W-1:0]] <= cfg_wdata;
        else if (cfg_addr == A_THR)
          r_threshold <= cfg_wdata[THRESHOLD_BITS-1:0];
        else if (cfg_addr == A_SHF)
          r_shift <= cfg_wdata[2:0];
      end
      if (in_valid) begin
        r_inputs <= in_data;
        r_idx    <= '0;
        r_acc    <= '0;
      end
    end else if (r_state == S_RUN) begin
      r_membrane[r_idx]  <= dp_new_membrane;
      r_was_spike[r_idx] <= dp_is_spike;
      r_acc              <= w_acc_next;
      if (w_last) begin
        r_out_spikes <= w_acc_next;
        r_idx        <= '0;
      end else begin
        r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

  assign out_spikes       = r_out_spikes;
  assign dp_inputs        = r_inputs;
  assign dp_weights       = r_weights[r_idx];
  assign dp_last_membrane = r_membrane[r_idx];
  assign dp_was_spike     = r_was_spike[r_idx];
  assign dp_threshold     = r_threshold;
  assign dp_shift         = r_shift;

endmodule

// File: tb/tb_lif_neuron_scheduler.sv
// Scoreboard bench for lif_neuron_scheduler with a popcount neuron stub
// and a per-timestep array model of all virtual neurons.
module tb_lif_neuron_scheduler;

  localparam int N  = 4;
  localparam int IN = 8;
  localparam int MB = 5;
  localparam int TB = 4;
  localparam int IW = 2;

  logic          clk;
  logic          reset;
  logic          cfg_we;
  logic [IW:0]   cfg_addr;
  logic [IN-1:0] cfg_wdata;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [IN-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_spikes;
  logic          busy;
  logic [IN-1:0] dp_inputs;
  logic [IN-1:0] dp_weights;
  logic [MB-1:0] dp_last_membrane;
  logic          dp_was_spike;
  logic [TB-1:0] dp_threshold;
  logic [2:0]    dp_shift;
  logic [MB-1:0] dp_new_membrane;
  logic          dp_is_spike;

  lif_neuron_scheduler dut (
    .clk(clk), .reset(reset),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_spikes(out_spikes), .busy(busy),
    .dp_inputs(dp_inputs), .dp_weights(dp_weights),
    .dp_last_membrane(dp_last_membrane), .dp_was_spike(dp_was_spike),
    .dp_threshold(dp_threshold), .dp_shift(dp_shift),
    .dp_new_membrane(dp_new_membrane), .dp_is_spike(dp_is_spike)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [MB-1:0] w_sum;
  always_comb begin
    w_sum           = dp_last_membrane + MB'($countones(dp_inputs & dp_weights));
    dp_is_spike     = (w_sum >= {1'b0, dp_threshold});
    dp_new_membrane = dp_is_spike ? '0 : w_sum;
  end

  logic rnd_en = 1'b0;
  logic or_man = 1'b0;
  logic r_rnd  = 1'b1;
  always @(negedge clk) r_rnd <= ($urandom_range(0, 3) != 0);
  assign out_ready = rnd_en ? r_rnd : or_man;

  logic [IN-1:0] m_w [N];
  int            m_mem [N];
  logic [N-1:0]  m_ws;
  int            m_thr;
  int            m_shift;
  logic [N-1:0]  exp_q [$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: bound expired (t=%0t)", nm, $time);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_w[i]   = '1;
      m_mem[i] = 0;
    end
    m_ws    = '0;
    m_thr   = 5;
    m_shift = 0;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < N; i++) m_mem[i] = 0;
    m_ws = '0;
  endfunction

  function automatic void model_cfg(input logic [IW:0] a, input logic [IN-1:0] d);
    if (a < 3'(N)) m_w[a[IW-1:0]] = d;
    else if (a == 3'(N)) m_thr = int'(d[TB-1:0]);
    else if (a == 3'(N + 1)) m_shift = int'(d[2:0]);
  endfunction

  // Every neuron integrates popcount of its matched inputs, fires at threshold
  function automatic logic [N-1:0] model_step(input logic [IN-1:0] d);
    logic [N-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) begin
      int v;
      v = m_mem[i] + $countones(d & m_w[i]);
      if (v >= m_thr) begin
        s[i] = 1'b1;
        m_mem[i] = 0;
        m_ws[i] = 1'b1;
      end else begin
        m_mem[i] = v;
        m_ws[i] = 1'b0;
      end
    end
    return s;
  endfunction

  always @(negedge clk) begin
    #1;
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) fail("unexpected_output");
      else check("out_spikes", 32'(out_spikes), 32'(exp_q.pop_front()));
    end
  end

  task automatic issue(input logic [IN-1:0] d, input bit do_cfg,
                       input logic [IW:0] a, input logic [IN-1:0] wd,
                       input bit do_clr, input bit push, output int hs);
    int t;
    t = 0;
    hs = 0;
    @(negedge clk);
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      fail("in_ready_wait");
      return;
    end
    in_valid  = 1'b1;
    in_data   = d;
    cfg_we    = do_cfg;
    cfg_addr  = a;
    cfg_wdata = wd;
    clear     = do_clr;
    if (push) begin
      if (do_clr) model_clear();
      if (do_cfg) model_cfg(a, wd);
      exp_q.push_back(model_step(d));
    end
    @(posedge clk);
    hs = cyc;
    #1;
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic cfg_write(input logic [IW:0] a, input logic [IN-1:0] d);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    if (!busy) model_cfg(a, d);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (busy && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (busy) fail("idle_wait");
  endtask

  task automatic check_idle(input string nm);
    check({nm, "_thr"}, 32'(dp_threshold), 32'(m_thr));
    check({nm, "_shift"}, 32'(dp_shift), 32'(m_shift));
    check({nm, "_w0"}, 32'(dp_weights), 32'(m_w[0]));
    check({nm, "_mem0"}, 32'(dp_last_membrane), 32'(m_mem[0]));
    check({nm, "_ws0"}, 32'(dp_was_spike), 32'(m_ws[0]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs1, hs2, cnt, t;
    logic [IN-1:0] d;
    logic [IN-1:0] wd;
    logic [IW:0]   a;
    bit            dc, dl;
    reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    clear = 1'b0; in_valid = 1'b0; in_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_out_spikes", 32'(out_spikes), 0);
    check_idle("rst");

    or_man = 1'b1;
    issue(8'hFF, 0, '0, '0, 0, 1, hs1);
    cnt = 1;
    while (!out_valid && cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("latency", 32'(cnt), 32'(N + 1));
    wait_idle();
    check_idle("ff");

    cfg_write(3'(N), 8'h04);
    cfg_write(3'd1, 8'h00);
    cfg_write(3'd2, 8'h0F);
    wait_idle();
    check_idle("cfg");
    issue(8'h03, 0, '0, '0, 0, 1, hs1);
    issue(8'h03, 0, '0, '0, 0, 1, hs2);
    check("throughput", 32'(hs2 - hs1), 32'(N + 2));
    wait_idle();
    check_idle("two_step");

    or_man = 1'b0;
    issue(8'hA5, 0, '0, '0, 0, 1, hs1);
    t = 0;
    while (!out_valid && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!out_valid) fail("stall_out_valid");
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      #1;
      check("stall_valid", 32'(out_valid), 1);
      check("stall_in_ready", 32'(in_ready), 0);
      if (exp_q.size() > 0)
        check("stall_spikes", 32'(out_spikes), 32'(exp_q[0]));
    end
    @(negedge clk);
    d = 8'h3C;
    in_valid = 1'b1;
    in_data  = d;
    or_man   = 1'b1;
    exp_q.push_back(model_step(d));
    @(posedge clk);
    #1;
    check("release_in_ready", 32'(in_ready), 1);
    check("release_busy", 32'(busy), 0);
    @(posedge clk);
    #1;
    check("reaccept_busy", 32'(busy), 1);
    in_valid = 1'b0;
    wait_idle();

    issue(8'h0F, 0, '0, '0, 0, 1, hs1);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 3'(N); cfg_wdata = 8'h01;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    wait_idle();
    check("run_cfg_ignored", 32'(dp_threshold), 32'(m_thr));
    issue(8'h11, 1, 3'(N), 8'h01, 0, 1, hs1);
    wait_idle();
    check("coincident_cfg", 32'(dp_threshold), 1);
    check_idle("coinc");

    cfg_write(3'(N), 8'h07);
    cfg_write(3'd0, 8'h0F);
    issue(8'h03, 0, '0, '0, 0, 1, hs1);
    wait_idle();
    check("partial_mem0", 32'(dp_last_membrane), 32'(m_mem[0]));
    @(negedge clk);
    clear = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    clear = 1'b0;
    check_idle("clear");
    issue(8'h07, 0, '0, '0, 0, 1, hs1);
    wait_idle();
    check_idle("after_clear");

    issue(8'hFF, 0, '0, '0, 0, 0, hs1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < N + 4; k++) begin
      @(negedge clk);
      #1;
      check("abort_no_valid", 32'(out_valid), 0);
    end
    check("abort_in_ready", 32'(in_ready), 1);
    check_idle("abort");

    rnd_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        wait_idle();
        a  = 3'($urandom_range(0, 7));
        wd = 8'($urandom);
        if (a == 3'(N)) wd[3] = 1'b0;
        cfg_write(a, wd);
      end
      dc = ($urandom_range(0, 3) == 0);
      dl = ($urandom_range(0, 5) == 0);
      a  = 3'($urandom_range(0, 7));
      wd = 8'($urandom);
      if (a == 3'(N)) wd[3] = 1'b0;
      issue(8'($urandom), dc, a, wd, dl, 1, hs1);
    end
    wait_idle();
    rnd_en = 1'b0;
    check_idle("random_end");
    repeat (2) @(negedge clk);
    check("drain", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
